// File: rtl/spi_pkg.sv
// spi_pkg: shared types, FSM encodings and chip-select timing defaults for spi_arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [3:0] speed_t;

  // FSM encodings kept as plain constants so legacy tools can read them.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  localparam int CS_SETUP_DEF = 2;
  localparam int CS_HOLD_DEF  = 2;

  // A requested length of 0 stands for a full 256-byte transfer.
  function automatic logic [8:0] len_to_count(input byte_t len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: command/response bus between the arbiter and the SPI byte engine.
// Latency: n/a (wires only).
// Backpressure: engine throttles via I_spi_busy and holds I_spi_ready until an O_spi_read pulse.
// Ports: master = arbiter side (drives write/read/speed/data), slave = byte-engine side.
interface spi_arbiter_if;
  import spi_pkg::*;

  logic   O_spi_write;
  logic   O_spi_read;
  speed_t O_spi_speed;
  byte_t  O_spi_data;
  byte_t  I_spi_data;
  logic   I_spi_busy;
  logic   I_spi_ready;

  modport master (
    output O_spi_write, O_spi_read, O_spi_speed, O_spi_data,
    input  I_spi_data, I_spi_busy, I_spi_ready
  );

  modport slave (
    input  O_spi_write, O_spi_read, O_spi_speed, O_spi_data,
    output I_spi_data, I_spi_busy, I_spi_ready
  );
endinterface

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick, favouring the requester not served last.
// Latency: combinational.
// Backpressure: none; the caller decides when to act on o_any.
// Ports: i_req request bits, i_last last-served index, o_idx winner index, o_any any request.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_idx,
  output logic       o_any
);

  always_comb begin
    o_any = |i_req;
    // A contested pick goes to whoever was not served last; otherwise the lone requester wins.
    if (i_req[0] && i_req[1]) begin
      o_idx = ~i_last;
    end else begin
      o_idx = i_req[1];
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one SPI byte engine between two requesters, owning chip select and byte pacing.
// Latency: grant 1 clk after request in IDLE; first write CS_SETUP+2 clks after cs_n falls; cs_n rises CS_HOLD clks after the last read.
// Backpressure: bytes issued only when the engine is neither busy nor holding an unread RX byte.
// Ports: I_clk/I_rst, per-requester I_req/I_len/I_speed/I_tx_data in, O_gnt/O_tx_next/O_rx_*/O_done/O_cs_n out, bus = byte-engine master.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [1:0]  I_req,
  input  logic [15:0] I_len,
  input  logic [7:0]  I_speed,
  input  logic [15:0] I_tx_data,
  output logic [1:0]  O_gnt,
  output logic [1:0]  O_tx_next,
  output logic [7:0]  O_rx_data,
  output logic [1:0]  O_rx_valid,
  output logic [1:0]  O_done,
  output logic [1:0]  O_cs_n,
  spi_arbiter_if.master bus
);

  logic [2:0] r_state;
  logic [7:0] r_tmr;
  logic [8:0] r_rem;
  logic       r_idx;
  logic       r_last;
  logic [1:0] r_gnt;
  logic [1:0] r_cs_n;
  logic [1:0] r_tx_next;
  logic [1:0] r_rx_valid;
  logic [1:0] r_done;
  byte_t      r_rx_data;
  logic       r_spi_write;
  logic       r_spi_read;
  byte_t      r_spi_data;
  speed_t     r_spi_speed;

  logic       w_idx;
  logic       w_any;
  byte_t      w_tx_byte;

  rr_pick2 u_pick (
    .i_req  (I_req),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_tx_byte = r_idx ? I_tx_data[15:8] : I_tx_data[7:0];

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      r_state     <= ST_IDLE;
      r_tmr       <= 8'd0;
      r_rem       <= 9'd0;
      r_idx       <= 1'b0;
      r_last      <= 1'b1;
      r_gnt       <= 2'b00;
      r_cs_n      <= 2'b11;
      r_tx_next   <= 2'b00;
      r_rx_valid  <= 2'b00;
      r_done      <= 2'b00;
      r_rx_data   <= 8'd0;
      r_spi_write <= 1'b0;
      r_spi_read  <= 1'b0;
      r_spi_data  <= 8'd0;
      r_spi_speed <= 4'd0;
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      r_tx_next   <= 2'b00;
      r_rx_valid  <= 2'b00;
      r_done      <= 2'b00;
      r_spi_write <= 1'b0;
      r_spi_read  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Only reachable a cycle after HOLD released cs_n, so the bus always idles at least one cycle.
          if (w_any) begin
            r_idx       <= w_idx;
            r_rem       <= len_to_count(w_idx ? I_len[15:8] : I_len[7:0]);
            r_spi_speed <= w_idx ? I_speed[7:4] : I_speed[3:0];
            r_gnt       <= w_idx ? 2'b10 : 2'b01;
            r_cs_n      <= w_idx ? 2'b01 : 2'b10;
            r_tmr       <= 8'(CS_SETUP);
            r_state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_tmr == 8'd0) begin
            r_state <= ST_SEND;
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end
        ST_SEND: begin
          // Ready is still high in the cycle our read pulse is on the bus; wait for it to clear.
          if (!bus.I_spi_busy && !bus.I_spi_ready) begin
            r_spi_write <= 1'b1;
            r_spi_data  <= w_tx_byte;
            r_tx_next   <= r_gnt;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.I_spi_ready) begin
            r_spi_read <= 1'b1;
            r_rx_data  <= bus.I_spi_data;
            r_rx_valid <= r_gnt;
            r_rem      <= r_rem - 9'd1;
            if (r_rem == 9'd1) begin
              r_tmr   <= 8'(CS_HOLD);
              r_state <= ST_HOLD;
            end else begin
              r_state <= ST_SEND;
            end
          end
        end
        ST_HOLD: begin
          // Release on the edge whose decrement reaches zero, so cs_n rises CS_HOLD clocks after the final ready is taken.
          if (r_tmr <= 8'd1) begin
            r_cs_n  <= 2'b11;
            r_gnt   <= 2'b00;
            r_done  <= r_gnt;
            r_last  <= r_idx;
            r_state <= ST_IDLE;
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign O_gnt           = r_gnt;
  assign O_cs_n          = r_cs_n;
  assign O_tx_next       = r_tx_next;
  assign O_rx_valid      = r_rx_valid;
  assign O_rx_data       = r_rx_data;
  assign O_done          = r_done;
  assign bus.O_spi_write = r_spi_write;
  assign bus.O_spi_read  = r_spi_read;
  assign bus.O_spi_data  = r_spi_data;
  assign bus.O_spi_speed = r_spi_speed;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: randomized scoreboard bench for spi_arbiter with a loopback byte-engine model.
// Latency: n/a.
// Backpressure: engine model holds busy for a programmable number of cycles per byte.
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  typedef struct {
    int         req;
    int         cnt;
    logic [3:0] speed;
  } gnt_item_t;

  typedef struct {
    int         req;
    logic [7:0] data;
  } rx_item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  I_req = 2'b00;
  logic [15:0] I_len = 16'd0;
  logic [7:0]  I_speed = 8'd0;
  logic [15:0] I_tx_data = 16'd0;
  logic [1:0]  O_gnt, O_tx_next, O_rx_valid, O_done, O_cs_n;
  logic [7:0]  O_rx_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_arbiter_if u_bus ();

  spi_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .I_clk      (clk),
    .I_rst      (rst),
    .I_req      (I_req),
    .I_len      (I_len),
    .I_speed    (I_speed),
    .I_tx_data  (I_tx_data),
    .O_gnt      (O_gnt),
    .O_tx_next  (O_tx_next),
    .O_rx_data  (O_rx_data),
    .O_rx_valid (O_rx_valid),
    .O_done     (O_done),
    .O_cs_n     (O_cs_n),
    .bus        (u_bus)
  );

  // Reference data: what each grant should look like and which bytes must echo back, in order.
  gnt_item_t  exp_gnt[$];
  rx_item_t   exp_rx[$];
  logic [7:0] txq0[$];
  logic [7:0] txq1[$];
  logic [7:0] pat[3] = '{8'hA5, 8'h5A, 8'hFF};
  bit         use_pat = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [1:0] oh(input int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  // Loopback byte engine: busy for busy_len+1 cycles after a write, then presents the same byte until read.
  int         busy_len = 1;
  int         eng_cnt;
  logic [7:0] eng_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_bus.I_spi_busy  <= 1'b0;
      u_bus.I_spi_ready <= 1'b0;
      u_bus.I_spi_data  <= 8'd0;
      eng_cnt           <= 0;
      eng_lat           <= 8'd0;
    end else begin
      if (u_bus.O_spi_read) u_bus.I_spi_ready <= 1'b0;
      if (u_bus.O_spi_write) begin
        u_bus.I_spi_busy <= 1'b1;
        eng_cnt          <= busy_len;
        eng_lat          <= u_bus.O_spi_data;
      end else if (u_bus.I_spi_busy) begin
        if (eng_cnt == 0) begin
          u_bus.I_spi_busy  <= 1'b0;
          u_bus.I_spi_ready <= 1'b1;
          u_bus.I_spi_data  <= eng_lat;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event; also drives requester TX bytes.
  int         cyc = 0;
  int         rx_seen = 0;
  int         wr_cnt, grant_cyc, last_rd_cyc;
  bit         cur_vld = 1'b0;
  bit         first_wr;
  gnt_item_t  cur;
  rx_item_t   rit;
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] prev_cs  = 2'b11;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_gnt.delete();
      exp_rx.delete();
      txq0.delete();
      txq1.delete();
      cur_vld  = 1'b0;
      prev_gnt = 2'b00;
      prev_cs  = 2'b11;
      I_tx_data = 16'd0;
    end else begin
      if (prev_gnt == 2'b00 && O_gnt != 2'b00) begin
        check("idle_gap_cs_n", {30'd0, prev_cs}, 32'd3);
        if (exp_gnt.size() == 0) begin
          flag("unexpected_grant");
        end else begin
          cur = exp_gnt.pop_front();
          cur_vld = 1'b1;
          check("grant_req", {30'd0, O_gnt}, {30'd0, oh(cur.req)});
          check("grant_speed", {28'd0, u_bus.O_spi_speed}, {28'd0, cur.speed});
          wr_cnt    = 0;
          grant_cyc = cyc;
          first_wr  = 1'b1;
        end
      end
      if (O_done != 2'b00) begin
        if (!cur_vld) begin
          flag("unexpected_done");
        end else begin
          check("done_req", {30'd0, O_done}, {30'd0, oh(cur.req)});
          check("write_count", wr_cnt, cur.cnt);
          check("cs_hold_clocks", cyc - last_rd_cyc, CS_HOLD);
          check("done_cs_n", {30'd0, O_cs_n}, 32'd3);
          check("done_gnt", {30'd0, O_gnt}, 32'd0);
          cur_vld = 1'b0;
        end
      end else if (cur_vld) begin
        check("active_gnt", {30'd0, O_gnt}, {30'd0, oh(cur.req)});
        check("active_cs_n", {30'd0, O_cs_n}, {30'd0, ~oh(cur.req)});
      end else begin
        check("idle_cs_n", {30'd0, O_cs_n}, 32'd3);
      end
      if (u_bus.O_spi_write) begin
        check("write_while_engine_busy", {31'd0, u_bus.I_spi_busy | u_bus.I_spi_ready}, 32'd0);
        wr_cnt++;
        if (first_wr && cur_vld) begin
          check("cs_setup_clocks", {31'd0, (cyc - grant_cyc) >= CS_SETUP}, 32'd1);
          first_wr = 1'b0;
        end
      end
      if (u_bus.O_spi_read) last_rd_cyc = cyc;
      if (O_rx_valid != 2'b00) begin
        rx_seen++;
        if (exp_rx.size() == 0) begin
          flag("unexpected_rx_valid");
        end else begin
          rit = exp_rx.pop_front();
          check("rx_req", {30'd0, O_rx_valid}, {30'd0, oh(rit.req)});
          check("rx_data", {24'd0, O_rx_data}, {24'd0, rit.data});
        end
      end
      if (O_tx_next[0] && txq0.size() > 0) void'(txq0.pop_front());
      if (O_tx_next[1] && txq1.size() > 0) void'(txq1.pop_front());
      I_tx_data[7:0]  = (txq0.size() > 0) ? txq0[0] : 8'd0;
      I_tx_data[15:8] = (txq1.size() > 0) ? txq1[0] : 8'd0;
      prev_gnt = O_gnt;
      prev_cs  = O_cs_n;
    end
  end

  task automatic issue(input int r, input logic [7:0] len, input logic [3:0] spd);
    int         n;
    gnt_item_t  g;
    rx_item_t   x;
    logic [7:0] b;
    n = (len == 8'd0) ? 256 : int'(len);
    g.req = r; g.cnt = n; g.speed = spd;
    exp_gnt.push_back(g);
    for (int i = 0; i < n; i++) begin
      b = (use_pat && i < 3) ? pat[i] : 8'($urandom);
      if (r == 0) txq0.push_back(b); else txq1.push_back(b);
      x.req = r; x.data = b;
      exp_rx.push_back(x);
    end
    I_len[8*r +: 8]   = len;
    I_speed[4*r +: 4] = spd;
    I_req[r]          = 1'b1;
  endtask

  task automatic wait_gnt(input int r);
    int n = 0;
    while (!O_gnt[r] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!O_gnt[r]) flag("grant_timeout");
  endtask

  task automatic wait_done(input int r, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      seen = O_done[r];
    end
    if (!seen) flag("done_timeout");
  endtask

  task automatic run_single(input int r, input logic [7:0] len, input logic [3:0] spd);
    issue(r, len, spd);
    wait_gnt(r);
    I_req[r] = 1'b0;
    wait_done(r, 6000);
  endtask

  task automatic hold_reset();
    I_req = 2'b00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", {30'd0, O_cs_n}, 32'd3);
    check("rst_gnt", {30'd0, O_gnt}, 32'd0);
    check("rst_strobes", {24'd0, O_tx_next, O_rx_valid, O_done, u_bus.O_spi_write, u_bus.O_spi_read}, 32'd0);
    check("rst_data", {12'd0, O_rx_data, u_bus.O_spi_data, u_bus.O_spi_speed}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int base;
    int n;
    hold_reset();

    // Single request with fixed bytes.
    use_pat = 1'b1;
    run_single(0, 8'd3, 4'h6);
    use_pat = 1'b0;

    // Simultaneous requests straight after reset: requester 0 first.
    hold_reset();
    issue(0, 8'd2, 4'h3);
    issue(1, 8'd2, 4'hC);
    wait_gnt(0);
    I_req[0] = 1'b0;
    wait_gnt(1);
    I_req[1] = 1'b0;
    wait_done(1, 2000);

    // Full 256-byte transfer.
    busy_len = 0;
    run_single(1, 8'd0, 4'h9);

    // Slow engine.
    busy_len = 10;
    run_single(1, 8'd3, 4'h2);

    // Randomized single transactions.
    for (int t = 0; t < 6; t++) begin
      busy_len = $urandom_range(0, 3);
      run_single($urandom_range(0, 1), 8'($urandom_range(1, 5)), 4'($urandom));
    end

    // Reset mid-transaction after two of four bytes, then a fresh request.
    busy_len = 1;
    base = rx_seen;
    issue(0, 8'd4, 4'h5);
    wait_gnt(0);
    I_req[0] = 1'b0;
    n = 0;
    while (rx_seen < base + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (rx_seen < base + 2) flag("rx_wait_timeout");
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", {30'd0, O_cs_n}, 32'd3);
    check("abort_gnt", {30'd0, O_gnt}, 32'd0);
    check("abort_done", {30'd0, O_done}, 32'd0);
    hold_reset();
    run_single(1, 8'd2, 4'hA);

    // req1 held while req0 pulses: grants alternate 0,1,0,1.
    issue(0, 8'd1, 4'h1);
    @(negedge clk);
    issue(1, 8'd1, 4'h7);
    wait_gnt(0);
    I_req[0] = 1'b0;
    wait_gnt(1);
    issue(0, 8'd1, 4'h4);
    issue(1, 8'd1, 4'h7);
    wait_gnt(0);
    I_req[0] = 1'b0;
    wait_gnt(1);
    I_req[1] = 1'b0;
    wait_done(1, 2000);

    repeat (10) @(negedge clk);
    check("leftover_grants", exp_gnt.size(), 0);
    check("leftover_rx", exp_rx.size(), 0);
    check("leftover_active", {31'd0, cur_vld}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter CS_SETUP, default 2: clocks from O_cs_n falling to the first byte write.
REQ-002 Parameter CS_HOLD, default 2: clocks from the last byte's I_spi_ready to O_cs_n rising.
REQ-003 I_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 I_rst  in  1  asynchronous, active-high reset.
REQ-005 I_req  in  2  per-requester transaction request, level; bit r = requester r.
REQ-006 I_len  in  16  byte count; [7:0] = requester 0, [15:8] = requester 1; value 0 means 256.
REQ-007 I_speed  in  8  SPI speed code; [3:0] = requester 0, [7:4] = requester 1.
REQ-008 I_tx_data  in  16  next TX byte; [7:0] = requester 0, [15:8] = requester 1.
REQ-009 O_gnt  out  2  one-hot grant, held for the whole transaction.
REQ-010 O_tx_next  out  2  1-cycle strobe: the granted requester's TX byte was consumed; present the next byte.
REQ-011 O_rx_data  out  8  last received byte.
REQ-012 O_rx_valid  out  2  1-cycle strobe to the granted requester; O_rx_data is valid.
REQ-013 O_done  out  2  1-cycle strobe to the granted requester at transaction end.
REQ-014 O_cs_n  out  2  per-device chip select, active-low.
REQ-015 O_spi_write, O_spi_read  out  1 each  byte-engine command strobes.
REQ-016 O_spi_speed  out  4  latched speed code of the granted requester.
REQ-017 O_spi_data  out  8  TX byte to the byte engine.
REQ-018 I_spi_data  in  8  RX byte from the byte engine.
REQ-019 I_spi_busy  in  1  byte engine busy.
REQ-020 I_spi_ready  in  1  byte engine has an RX byte; level, held until an O_spi_read pulse.

Function
REQ-021 The state machine SHALL have the states IDLE, SETUP, SEND, WAIT and HOLD.
REQ-022 IDLE behaviour:
- Any I_req bit set: grant round-robin, preferring the requester not served last (requester 0 first after reset).
- On grant: latch length and speed, set O_gnt, drive the selected O_cs_n low, load the counter with CS_SETUP, go to SETUP.
REQ-023 SETUP SHALL decrement the counter and go to SEND on the cycle the counter reads 0.
REQ-024 SEND behaviour:
- Waits while I_spi_busy=1.
- When I_spi_busy=0, in one cycle: pulse O_spi_write, drive O_spi_data from the granted requester's I_tx_data slice, pulse O_tx_next, then go to WAIT.
REQ-025 WAIT behaviour:
- On I_spi_ready=1: pulse O_spi_read, register O_rx_data <= I_spi_data, pulse O_rx_valid the next cycle, and decrement the remaining count.
- Remaining count reaching 0: go to HOLD with the counter = CS_HOLD; otherwise go to SEND.
REQ-026 HOLD behaviour:
- Count down to 0, then drive O_cs_n all high, clear O_gnt, pulse O_done, record the last-served requester, and go to IDLE.
- IDLE SHALL spend at least 1 cycle with all O_cs_n high before any new grant.
REQ-027 The remaining count SHALL be 9 bits, with length 0 loaded as 256; no wrap-around.
REQ-028 Dropping I_req mid-transaction SHALL be ignored; the transaction runs to completion.
REQ-029 Simultaneous requests SHALL be resolved by the round-robin rule; a request already held by the served requester SHALL NOT starve the other requester.
REQ-030 At most one O_cs_n bit SHALL be low at any time; O_gnt and O_cs_n SHALL always agree.
REQ-031 O_spi_write SHALL never be asserted while I_spi_busy=1 or while I_spi_ready=1 is pending.

Reset
REQ-032 While I_rst=1 (asynchronous), the block SHALL drive:
- state = IDLE
- O_cs_n = 2'b11
- O_gnt, O_tx_next, O_rx_valid, O_done, O_spi_write, O_spi_read = 0
- O_spi_data, O_rx_data, O_spi_speed = 0
- last-served pointer = 1, so requester 0 wins first.
REQ-033 Reset asserted mid-transaction SHALL abort with O_cs_n high immediately and no O_done pulse.

Structure
REQ-034 State encodings and the CS_SETUP/CS_HOLD defaults SHALL live in a shared package spi_pkg.
REQ-035 The block SHALL be a single module; the round-robin pick MAY be a sub-module rr_pick2.

Verification
REQ-036 Single request: req0, len=3, tx 0xA5/0x5A/0xFF, loopback byte engine -> cs_n[0] low ≥2 cycles before the first write, 3 rx_valid with the echoed bytes, done[0] once, cs_n[0] high 2 cycles after the last ready.
REQ-037 Simultaneous req=2'b11 after reset -> requester 0 served first, then requester 1, with an idle gap of ≥1 cycle with cs_n=2'b11.
REQ-038 len=0 -> exactly 256 O_spi_write pulses, then done.
REQ-039 Engine holds busy for 10 cycles after a write -> no second O_spi_write until busy=0 and ready has been consumed.
REQ-040 Reset asserted after byte 2 of 4 -> cs_n=2'b11 immediately, no done; a fresh request afterwards completes normally.
REQ-041 req1 held continuously while req0 pulses -> grants alternate 0,1,0,1.
